writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
Registered writeback stage for the RISC-V core. It replaces the single-cycle combinational writeback select with a handshaked, parametrised unit. It accepts one retiring instruction per handshake, waits on a variable-latency data memory for loads, and aligns and sign/zero-extends load data by byte offset. It drives the register-file write port, and flags load timeouts and misaligned loads.

Parameters:
XLEN, 32, datapath width (pc, alu_out, imm, memory data, write data); XLEN >= 32
OP_W, 6, width of the control-unit opcode (cuOPType from the shared package)
TIMEOUT_CYCLES, 255, cycles spent in LOAD_WAIT without mem_ack before a load is abandoned; must be >= 1
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived; do not override)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  retiring instruction present
in_ready  out  1  unit can accept; high only in IDLE (combinational from state)
cu_op  in  OP_W  decoded operation
pc  in  XLEN  instruction address
alu_out  in  XLEN  ALU result
imm  in  XLEN  decoded immediate
rd  in  5  destination register index
addr_low  in  2  effective address bits [1:0] for loads
mem_rdata  in  XLEN  word-aligned data-memory read data
mem_ack  in  1  memory read data valid (single-cycle pulse)
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  5  register-file write index (registered)
rf_wdata  out  XLEN  register-file write data (registered)
busy  out  1  high in LOAD_WAIT (pipeline stall)
load_err  out  1  one-cycle pulse on load timeout
misalign_err  out  1  one-cycle pulse on misaligned LH/LHU/LW

Behaviour:
- States: IDLE, LOAD_WAIT. Reset leaves the unit in IDLE, timeout counter 0, and all registered outputs 0 (rf_we, rf_waddr, rf_wdata, load_err, misalign_err). Reset mid-LOAD_WAIT abandons the load with no write and no error pulse.
- Accept = in_valid && in_ready. rf_we, load_err and misalign_err are 0 in every cycle that does not satisfy one of the conditions below.
- IDLE, accept, non-load op: the result is registered with latency 1 (rf_we high in the next cycle).
  - LUI: {imm[31:12],12'b0}.
  - AUIPC: pc + {imm[31:12],12'b0}, modulo 2^XLEN.
  - JAL/JALR: pc + 4, wraps modulo 2^XLEN.
  - SB/SH/SW, BEQ..BGEU and CU_ERROR: no write.
  - All other ops: alu_out.
- IDLE, accept, load op:
  - Misaligned if (LH/LHU && addr_low[0]) or (LW && addr_low != 0). Misaligned: pulse misalign_err next cycle, no write, stay IDLE.
  - Aligned: latch rd, op and addr_low, clear the counter, go to LOAD_WAIT.
- LOAD_WAIT, mem_ack: select and extend the data.
  - LB: byte lane addr_low, sign-extended.
  - LBU: byte lane addr_low, zero-extended.
  - LH: half lane addr_low[1], sign-extended.
  - LHU: half lane addr_low[1], zero-extended.
  - LW: whole word, sign-extended to XLEN.
  - Register the result (rf_we next cycle) and return to IDLE. A new instruction may be accepted in the cycle after the return, i.e. the cycle rf_we is high.
- LOAD_WAIT, no ack: increment the counter. When the counter equals TIMEOUT_CYCLES-1 and no ack is present, pulse load_err next cycle, no write, return to IDLE. If ack and terminal count coincide, ack wins.
- mem_ack while in IDLE is ignored.
- rd == 0: rf_we is forced 0 for any op. Load timing, misalign checks and error pulses are unchanged.
- busy = (state == LOAD_WAIT). in_ready = !busy. Inputs other than mem_* are sampled only on accept.

Decomposition:
- Shared package core_pkg holds cuOPType, OP_W, a XLEN default, and helper functions is_load(op) and writes_rd(op).
- One sub-module, load_align: purely combinational. Inputs: word, addr_low, op. Output: extended XLEN data. The FSM, counter and output registers stay in writeback_unit.

Test Plan:
- Reset then ADDI, rd=5, alu_out=0x0000_0042 -> one cycle later rf_we=1, rf_waddr=5, rf_wdata=0x42; all outputs 0 during reset.
- LB, addr_low=2, mem_rdata=0x1280_FF34, ack 3 cycles after accept -> busy high 3 cycles, then rf_wdata=0x0000_0080 sign-extended to 0xFFFF_FF80. LBU same stimulus -> 0x0000_0080.
- LH, addr_low=2, mem_rdata=0x8001_1234 -> 0xFFFF_8001. LHU, addr_low=1 -> misalign_err pulse, no write, in_ready stays 1.
- JAL, pc=0xFFFF_FFFC -> rf_wdata=0x0000_0000 (wrap). AUIPC, pc=0x1000, imm=0x0001_2000 -> 0x0001_3000. SW -> rf_we stays 0.
- LW with TIMEOUT_CYCLES=4 and no ack -> load_err pulses exactly once, no write, back to IDLE. Second LW with ack on the terminal-count cycle -> write occurs, no load_err.
- LW to rd=0 with ack -> rf_we=0. rst asserted during LOAD_WAIT, then a late mem_ack -> ignored, no write.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
//------------------------------------------------------------------------------
// core_pkg : shared control-unit opcode set and writeback classification helpers
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package core_pkg;

  localparam int OP_W         = 6;
  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [OP_W-1:0] {
    CU_ERROR = 6'd0,
    CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
    CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
    CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU,
    CU_SB, CU_SH, CU_SW,
    CU_ADDI, CU_SLTI, CU_SLTIU, CU_XORI, CU_ORI, CU_ANDI,
    CU_SLLI, CU_SRLI, CU_SRAI,
    CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_SRA, CU_OR, CU_AND
  } cuOPType;

  function automatic logic is_load(input cuOPType op);
    return op inside {CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU};
  endfunction

  function automatic logic writes_rd(input cuOPType op);
    return !(op inside {CU_SB, CU_SH, CU_SW,
                        CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
                        CU_ERROR});
  endfunction

endpackage

`default_nettype wire

// File: rtl/writeback_unit_if.sv
//------------------------------------------------------------------------------
// writeback_unit_if : retire, data-memory return and register-file write bus
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface writeback_unit_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 6
) ();
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] cu_op;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  logic [1:0]      addr_low;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            busy;
  logic            load_err;
  logic            misalign_err;

  modport master (
    output in_valid, cu_op, pc, alu_out, imm, rd, addr_low, mem_rdata, mem_ack,
    input  in_ready, rf_we, rf_waddr, rf_wdata, busy, load_err, misalign_err
  );

  modport slave (
    input  in_valid, cu_op, pc, alu_out, imm, rd, addr_low, mem_rdata, mem_ack,
    output in_ready, rf_we, rf_waddr, rf_wdata, busy, load_err, misalign_err
  );
endinterface

`default_nettype wire

// File: rtl/writeback_unit_load_align.sv
//------------------------------------------------------------------------------
// load_align : byte/half/word lane select and sign/zero extension of load data
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr_low,
  input  cuOPType         op,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{addr_low, 3'b000} +: 8];
    lane_h = word[{addr_low[1], 4'b0000} +: 16];
    case (op)
      CU_LB:   data = XLEN'($signed(lane_b));
      CU_LBU:  data = XLEN'(lane_b);
      CU_LH:   data = XLEN'($signed(lane_h));
      CU_LHU:  data = XLEN'(lane_h);
      default: data = XLEN'($signed(word[31:0]));
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
//------------------------------------------------------------------------------
// writeback_unit : handshaked writeback stage with variable-latency load wait
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module writeback_unit
  import core_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int OP_W           = 6,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic             clk,
  input logic             rst,
  writeback_unit_if.slave wb
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  cuOPType         op_q;
  logic [4:0]      rd_q;
  logic [1:0]      addr_q;
  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            load_err_q;
  logic            misalign_q;

  cuOPType         op_in;
  logic            accept;
  logic            misaligned;
  logic [XLEN-1:0] upper_imm;
  logic [XLEN-1:0] direct_data;
  logic [XLEN-1:0] load_data;

  assign op_in       = cuOPType'(wb.cu_op);
  assign wb.busy     = (state == LOAD_WAIT);
  assign wb.in_ready = (state != LOAD_WAIT);
  assign accept      = wb.in_valid && wb.in_ready;
  assign upper_imm   = {wb.imm[XLEN-1:12], 12'b0};

  always_comb begin
    misaligned = ((op_in == CU_LH || op_in == CU_LHU) && wb.addr_low[0]) ||
                 (op_in == CU_LW && wb.addr_low != 2'b00);
    case (op_in)
      CU_LUI:          direct_data = upper_imm;
      CU_AUIPC:        direct_data = wb.pc + upper_imm;
      CU_JAL, CU_JALR: direct_data = wb.pc + XLEN'(4);
      default:         direct_data = wb.alu_out;
    endcase
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .word     (wb.mem_rdata),
    .addr_low (addr_q),
    .op       (op_q),
    .data     (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= CU_ERROR;
      rd_q       <= '0;
      addr_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      load_err_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      rf_we_q    <= 1'b0;
      load_err_q <= 1'b0;
      misalign_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_load(op_in)) begin
              if (misaligned) begin
                misalign_q <= 1'b1;
              end else begin
                op_q   <= op_in;
                rd_q   <= wb.rd;
                addr_q <= wb.addr_low;
                cnt    <= '0;
                state  <= LOAD_WAIT;
              end
            end else if (writes_rd(op_in) && wb.rd != 5'd0) begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= wb.rd;
              rf_wdata_q <= direct_data;
            end
          end
        end
        LOAD_WAIT: begin
          // An ack on the terminal-count cycle still completes the load
          if (wb.mem_ack) begin
            rf_we_q    <= (rd_q != 5'd0);
            rf_waddr_q <= rd_q;
            rf_wdata_q <= load_data;
            state      <= IDLE;
          end else if (cnt == TERM_CNT) begin
            load_err_q <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb.rf_we        = rf_we_q;
  assign wb.rf_waddr     = rf_waddr_q;
  assign wb.rf_wdata     = rf_wdata_q;
  assign wb.load_err     = load_err_q;
  assign wb.misalign_err = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
//------------------------------------------------------------------------------
// tb_writeback_unit : directed and randomized transactions against a reference model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_writeback_unit;
  import core_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  writeback_unit_if #(.XLEN(32), .OP_W(6)) wb_bus ();

  writeback_unit #(.XLEN(32), .OP_W(6), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb_bus)
  );

  cuOPType ops[] = '{CU_ERROR, CU_LUI, CU_AUIPC, CU_JAL, CU_JALR, CU_BEQ, CU_BGEU,
                     CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU, CU_SB, CU_SH, CU_SW,
                     CU_ADDI, CU_XORI, CU_ADD, CU_SUB, CU_SRA, CU_AND};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] load_model(input cuOPType op, input logic [31:0] w,
                                             input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * a));
    h = 16'(w >> (16 * a[1]));
    case (op)
      CU_LB:   return {{24{b[7]}}, b};
      CU_LBU:  return {24'h0, b};
      CU_LH:   return {{16{h[15]}}, h};
      CU_LHU:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic scramble_inputs();
    wb_bus.cu_op    = 6'($urandom);
    wb_bus.pc       = $urandom;
    wb_bus.alu_out  = $urandom;
    wb_bus.imm      = $urandom;
    wb_bus.rd       = 5'($urandom);
    wb_bus.addr_low = 2'($urandom);
  endtask

  // ack_dly: LOAD_WAIT cycle (1-based) carrying mem_ack; beyond TMO means none arrives
  task automatic run_txn(input cuOPType op, input logic [4:0] rdi, input logic [31:0] pci,
                         input logic [31:0] alui, input logic [31:0] immi,
                         input logic [1:0] al, input logic [31:0] word, input int ack_dly);
    logic ld, mis, to, wr;
    logic [31:0] exp;
    ld  = op inside {CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU};
    mis = ((op == CU_LH || op == CU_LHU) && al[0]) || (op == CU_LW && al != 2'd0);
    to  = ld && !mis && (ack_dly > TMO);
    case (op)
      CU_LUI:          exp = {immi[31:12], 12'h0};
      CU_AUIPC:        exp = pci + {immi[31:12], 12'h0};
      CU_JAL, CU_JALR: exp = pci + 32'd4;
      default:         exp = alui;
    endcase
    if (ld) exp = load_model(op, word, al);
    wr = (rdi != 5'd0) && !mis && !to &&
         !(op inside {CU_SB, CU_SH, CU_SW, CU_BEQ, CU_BNE, CU_BLT, CU_BGE,
                      CU_BLTU, CU_BGEU, CU_ERROR});

    check_eq("in_ready_idle", wb_bus.in_ready, 1);
    wb_bus.in_valid  = 1'b1;
    wb_bus.cu_op     = op;
    wb_bus.rd        = rdi;
    wb_bus.pc        = pci;
    wb_bus.alu_out   = alui;
    wb_bus.imm       = immi;
    wb_bus.addr_low  = al;
    wb_bus.mem_ack   = 1'($urandom);
    wb_bus.mem_rdata = $urandom;
    @(negedge clk);
    wb_bus.in_valid = 1'b0;
    wb_bus.mem_ack  = 1'b0;
    scramble_inputs();

    if (ld && !mis) begin
      for (int i = 1; i <= TMO; i++) begin
        check_eq("busy_wait", wb_bus.busy, 1);
        check_eq("in_ready_wait", wb_bus.in_ready, 0);
        check_eq("rf_we_wait", wb_bus.rf_we, 0);
        check_eq("load_err_wait", wb_bus.load_err, 0);
        if (i == ack_dly) begin
          wb_bus.mem_ack   = 1'b1;
          wb_bus.mem_rdata = word;
        end
        @(negedge clk);
        wb_bus.mem_ack   = 1'b0;
        wb_bus.mem_rdata = $urandom;
        if (i == ack_dly) break;
      end
    end

    check_eq("rf_we", wb_bus.rf_we, wr);
    if (wr) begin
      check_eq("rf_waddr", wb_bus.rf_waddr, rdi);
      check_eq("rf_wdata", wb_bus.rf_wdata, exp);
    end
    check_eq("misalign_err", wb_bus.misalign_err, mis);
    check_eq("load_err", wb_bus.load_err, to);
    check_eq("busy_done", wb_bus.busy, 0);
    if (mis || to) begin
      @(negedge clk);
      check_eq("err_single_pulse", {wb_bus.load_err, wb_bus.misalign_err}, 0);
      check_eq("rf_we_after_err", wb_bus.rf_we, 0);
      check_eq("in_ready_after_err", wb_bus.in_ready, 1);
    end
  endtask

  initial begin
    wb_bus.in_valid  = 1'b0;
    wb_bus.mem_ack   = 1'b0;
    wb_bus.mem_rdata = '0;
    scramble_inputs();

    repeat (3) begin
      @(negedge clk);
      check_eq("reset_outputs", {wb_bus.rf_we, wb_bus.rf_waddr, wb_bus.load_err,
                                 wb_bus.misalign_err, wb_bus.busy}, 0);
      check_eq("reset_wdata", wb_bus.rf_wdata, 0);
    end
    rst = 1'b0;

    run_txn(CU_ADDI,  5'd5, 32'h0,         32'h0000_0042, 32'h0,         2'd0, 32'h0,         0);
    run_txn(CU_LB,    5'd6, 32'h0,         32'h0,         32'h0,         2'd2, 32'h1280_FF34, 3);
    run_txn(CU_LBU,   5'd6, 32'h0,         32'h0,         32'h0,         2'd2, 32'h1280_FF34, 3);
    run_txn(CU_LH,    5'd7, 32'h0,         32'h0,         32'h0,         2'd2, 32'h8001_1234, 1);
    run_txn(CU_LHU,   5'd7, 32'h0,         32'h0,         32'h0,         2'd1, 32'h8001_1234, 1);
    run_txn(CU_JAL,   5'd1, 32'hFFFF_FFFC, 32'h0,         32'h0,         2'd0, 32'h0,         0);
    run_txn(CU_AUIPC, 5'd2, 32'h0000_1000, 32'h0,         32'h0001_2000, 2'd0, 32'h0,         0);
    run_txn(CU_SW,    5'd3, 32'h0,         32'h1234_5678, 32'h0,         2'd0, 32'h0,         0);
    run_txn(CU_LW,    5'd8, 32'h0,         32'h0,         32'h0,         2'd0, 32'hDEAD_BEEF, TMO + 5);
    run_txn(CU_LW,    5'd9, 32'h0,         32'h0,         32'h0,         2'd0, 32'hCAFE_F00D, TMO);
    run_txn(CU_LW,    5'd0, 32'h0,         32'h0,         32'h0,         2'd0, 32'h1111_2222, 2);
    run_txn(CU_LUI,   5'd4, 32'h0,         32'h0,         32'hABCD_E123, 2'd0, 32'h0,         0);

    // Reset during LOAD_WAIT: the later ack must be dropped
    wb_bus.in_valid = 1'b1;
    wb_bus.cu_op    = CU_LW;
    wb_bus.rd       = 5'd10;
    wb_bus.addr_low = 2'd0;
    @(negedge clk);
    wb_bus.in_valid = 1'b0;
    check_eq("busy_before_rst", wb_bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("busy_in_rst", wb_bus.busy, 0);
    wb_bus.mem_ack   = 1'b1;
    wb_bus.mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    wb_bus.mem_ack = 1'b0;
    check_eq("late_ack_no_write", wb_bus.rf_we, 0);
    check_eq("late_ack_no_err", wb_bus.load_err, 0);
    check_eq("late_ack_idle", wb_bus.busy, 0);

    for (int n = 0; n < 200; n++) begin
      run_txn(ops[$urandom_range(0, ops.size() - 1)],
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
              $urandom, $urandom, $urandom, 2'($urandom), $urandom,
              int'($urandom_range(1, TMO + 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
